mem_request_arbiter: RTL and testbench

Sequencer that shares the single RAM port between the PC/instruction-fetch path and the load/store data path of the core. It accepts one fetch requester and one data requester, grants the RAM to one at a time (data first), drives the RAM address, store-data and enable strobes, waits for the RAM handshake, and returns the loaded word with a one-cycle ready pulse (`i_ready` / `d_ready`) to the winning requester. A transaction watchdog converts a hung RAM into a sticky error instead of a stalled core.

---
 rtl/mem_request_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_arbiter.sv
// -----------------------------------------------------------------------------
// mem_request_arbiter
//
// Shares the single RAM port between the instruction-fetch path and the
// load/store data path. One access is in flight at a time; data requests win
// over fetch requests. Each access runs IDLE -> BUSY -> RESP. RESP carries a
// one-cycle ready pulse to the requester that owned the access. A watchdog
// aborts an access that the RAM never completes and raises a sticky bus_error.
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   i_req, imemaddr       : fetch request (held until i_ready) and byte address
//   imemload, i_ready     : fetched word and its one-cycle completion pulse
//   d_ren, d_wen          : data read / write request (held until d_ready)
//   dmmaddr, dmmstore     : data byte address and store data
//   dmmload, d_ready      : load data and its one-cycle completion pulse
//   ramaddr, ramstore     : word-aligned RAM address and RAM write data
//   ram_ren, ram_wen      : RAM strobes, high only while BUSY
//   ramload, ram_ready    : RAM read data and access-complete handshake
//   bus_error             : sticky watchdog error, cleared only by reset
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module mem_request_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        i_ready,
   input  logic        d_ren,
   input  logic        d_wen,
   input  logic [31:0] dmmaddr,
   input  logic [31:0] dmmstore,
   output logic [31:0] dmmload,
   output logic        d_ready,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        ram_ren,
   output logic        ram_wen,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic        bus_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Last BUSY cycle the watchdog tolerates without ram_ready.
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

   state_t      state_q,     state_d;
   logic        owner_q,     owner_d;      // 0 = fetch, 1 = data
   logic        is_write_q,  is_write_d;
   logic [7:0]  wd_cnt_q,    wd_cnt_d;
   logic [31:0] ramaddr_q,   ramaddr_d;
   logic [31:0] ramstore_q,  ramstore_d;
   logic [31:0] imemload_q,  imemload_d;
   logic [31:0] dmmload_q,   dmmload_d;
   logic        ram_ren_q,   ram_ren_d;
   logic        ram_wen_q,   ram_wen_d;
   logic        i_ready_q,   i_ready_d;
   logic        d_ready_q,   d_ready_d;
   logic        bus_error_q, bus_error_d;

   // Byte-offset bits are dropped: the RAM is word addressed.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imemaddr[1:0], dmmaddr[1:0]};

   always_comb begin
      // NOTE: every _d starts as its _q (or 0 for pulses) so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      owner_d     = owner_q;
      is_write_d  = is_write_q;
      wd_cnt_d    = wd_cnt_q;
      ramaddr_d   = ramaddr_q;
      ramstore_d  = ramstore_q;
      imemload_d  = imemload_q;
      dmmload_d   = dmmload_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      bus_error_d = bus_error_q;

      case (state_q)
         IDLE: begin
            // Fixed priority: data before fetch. A simultaneous read+write is
            // a write.
            if (d_ren || d_wen) begin
               owner_d    = 1'b1;
               is_write_d = d_wen;
               ramaddr_d  = {dmmaddr[31:2], 2'b00};
               ramstore_d = d_wen ? dmmstore : 32'd0;
               ram_wen_d  = d_wen;
               ram_ren_d  = !d_wen;
               wd_cnt_d   = 8'd0;
               state_d    = BUSY;
            end else if (i_req) begin
               owner_d    = 1'b0;
               is_write_d = 1'b0;
               ramaddr_d  = {imemaddr[31:2], 2'b00};
               ramstore_d = 32'd0;
               ram_wen_d  = 1'b0;
               ram_ren_d  = 1'b1;
               wd_cnt_d   = 8'd0;
               state_d    = BUSY;
            end
         end

         BUSY: begin
            // Completion has precedence over the watchdog in the same cycle.
            if (ram_ready) begin
               if (!owner_q) begin
                  imemload_d = ramload;
               end else if (!is_write_q) begin
                  dmmload_d = ramload;
               end
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               i_ready_d = !owner_q;
               d_ready_d = owner_q;
               state_d   = RESP;
            end else if (wd_cnt_q == WD_LIMIT) begin
               // Abort: the owner still gets its ready pulse, with zero data.
               if (!owner_q) begin
                  imemload_d = 32'd0;
               end else begin
                  dmmload_d = 32'd0;
               end
               bus_error_d = 1'b1;
               ram_ren_d   = 1'b0;
               ram_wen_d   = 1'b0;
               i_ready_d   = !owner_q;
               d_ready_d   = owner_q;
               state_d     = RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 8'd1;
            end
         end

         // Ready pulse is visible this cycle; requester inputs are not looked
         // at again until IDLE, giving the requester a cycle to drop them.
         RESP: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         is_write_q  <= 1'b0;
         wd_cnt_q    <= 8'd0;
         ramaddr_q   <= 32'd0;
         ramstore_q  <= 32'd0;
         imemload_q  <= 32'd0;
         dmmload_q   <= 32'd0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         is_write_q  <= is_write_d;
         wd_cnt_q    <= wd_cnt_d;
         ramaddr_q   <= ramaddr_d;
         ramstore_q  <= ramstore_d;
         imemload_q  <= imemload_d;
         dmmload_q   <= dmmload_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign imemload  = imemload_q;
   assign i_ready   = i_ready_q;
   assign dmmload   = dmmload_q;
   assign d_ready   = d_ready_q;
   assign ramaddr   = ramaddr_q;
   assign ramstore  = ramstore_q;
   assign ram_ren   = ram_ren_q;
   assign ram_wen   = ram_wen_q;
   assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_request_arbiter
//
// Scoreboard bench. The stimulus side decides each access up front (who wins,
// RAM latency, RAM data), predicts the visible outcome from the arbitration
// rules and pushes it into exp_q; the RAM model plays back the chosen latency
// and data; the monitor compares every RAM access start and every ready pulse
// against the head of exp_q. TIMEOUT is 4 so aborts are reachable quickly.
// -----------------------------------------------------------------------------
module tb_mem_request_arbiter;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        i_ready;
   logic        d_ren;
   logic        d_wen;
   logic [31:0] dmmaddr;
   logic [31:0] dmmstore;
   logic [31:0] dmmload;
   logic        d_ready;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ramload;
   logic        ram_ready;
   logic        bus_error;

   always #5 clk = ~clk;

   mem_request_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .imemaddr  (imemaddr),
      .imemload  (imemload),
      .i_ready   (i_ready),
      .d_ren     (d_ren),
      .d_wen     (d_wen),
      .dmmaddr   (dmmaddr),
      .dmmstore  (dmmstore),
      .dmmload   (dmmload),
      .d_ready   (d_ready),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ramload   (ramload),
      .ram_ready (ram_ready),
      .bus_error (bus_error)
   );

   // Expected outcome of one RAM access.
   typedef struct {
      bit          owner;     // 0 fetch, 1 data
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] imem;      // imemload after the access
      logic [31:0] dmem;      // dmmload after the access
      bit          err;       // bus_error after the access
      int          len;       // strobe cycles
   } exp_t;

   // What the RAM model does for one access.
   typedef struct {
      int          lat;       // BUSY cycles before ram_ready
      logic [31:0] data;
   } plan_t;

   exp_t  exp_q[$];
   plan_t plan_q[$];

   int checks   = 0;
   int failures = 0;

   // Architectural state predicted by the bench.
   logic [31:0] m_imem;
   logic [31:0] m_dmem;
   bit          m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event with nothing expected", name);
   endtask

   // ---------------------------------------------------------------- RAM model
   initial begin : ram_model
      bit    active;
      int    k;
      plan_t p;
      active    = 1'b0;
      k         = 0;
      p.lat     = 0;
      p.data    = '0;
      ram_ready = 1'b0;
      ramload   = '0;
      forever begin
         @(negedge clk);
         if (ram_ren || ram_wen) begin
            if (!active) begin
               active = 1'b1;
               k      = 0;
               if (plan_q.size() == 0) begin
                  p.lat  = 1000;
                  p.data = '0;
               end else begin
                  p = plan_q.pop_front();
               end
            end
            if (k == p.lat) begin
               ram_ready = 1'b1;
               ramload   = p.data;
            end else begin
               ram_ready = 1'b0;
               ramload   = $urandom;
            end
            k++;
         end else begin
            active    = 1'b0;
            ram_ready = 1'b0;
            ramload   = $urandom;
         end
      end
   end

   // ------------------------------------------------------------------ monitor
   initial begin : monitor
      bit   prev_strobe;
      int   slen;
      exp_t e;
      prev_strobe = 1'b0;
      slen        = 0;
      forever begin
         @(negedge clk);
         if (ram_ren || ram_wen) begin
            check("one_strobe", 32'(ram_ren & ram_wen), 32'd0);
            if (!prev_strobe) begin
               slen = 0;
               if (exp_q.size() == 0) begin
                  flag("unexpected_access");
               end else begin
                  e = exp_q[0];
                  check("ramaddr",  ramaddr,  e.addr);
                  check("ramstore", ramstore, e.store);
                  check("ram_wen",  32'(ram_wen), 32'(e.is_write));
               end
            end
            slen++;
         end
         if (i_ready || d_ready) begin
            check("one_ready", 32'(i_ready & d_ready), 32'd0);
            if (exp_q.size() == 0) begin
               flag("unexpected_ready");
            end else begin
               e = exp_q.pop_front();
               check("ready_owner",        32'(d_ready), 32'(e.owner));
               check("ready_after_strobe", 32'(prev_strobe), 32'd1);
               check("strobe_len",         slen, e.len);
               check("imemload",           imemload, e.imem);
               check("dmmload",            dmmload, e.dmem);
               check("bus_error",          32'(bus_error), 32'(e.err));
            end
         end
         prev_strobe = ram_ren || ram_wen;
      end
   end

   // ---------------------------------------------------------------- stimulus
   // One stimulus round: any combination of fetch and data request raised
   // together. Predicts both accesses, drives them, and holds each request
   // until its ready pulse is seen.
   task automatic run_txn(input bit f, input bit dr, input bit dw,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] ds,
                          input int lat_d, input logic [31:0] dat_d,
                          input int lat_f, input logic [31:0] dat_f);
      exp_t  e;
      plan_t p;
      bit    has_d;
      bit    pend_d;
      bit    pend_f;
      int    len_d;
      int    len_f;
      int    want_d;
      int    want_f;
      int    n;
      has_d = dr || dw;
      len_d = 0;
      len_f = 0;
      if (has_d) begin
         p.lat = lat_d;
         p.data = dat_d;
         plan_q.push_back(p);
         if (lat_d >= TIMEOUT) begin
            m_err  = 1'b1;
            m_dmem = 32'd0;
            len_d  = TIMEOUT;
         end else begin
            if (!dw) m_dmem = dat_d;
            len_d = lat_d + 1;
         end
         e.owner    = 1'b1;
         e.is_write = dw;
         e.addr     = da & 32'hFFFF_FFFC;
         e.store    = dw ? ds : 32'd0;
         e.imem     = m_imem;
         e.dmem     = m_dmem;
         e.err      = m_err;
         e.len      = len_d;
         exp_q.push_back(e);
      end
      if (f) begin
         p.lat = lat_f;
         p.data = dat_f;
         plan_q.push_back(p);
         if (lat_f >= TIMEOUT) begin
            m_err  = 1'b1;
            m_imem = 32'd0;
            len_f  = TIMEOUT;
         end else begin
            m_imem = dat_f;
            len_f  = lat_f + 1;
         end
         e.owner    = 1'b0;
         e.is_write = 1'b0;
         e.addr     = ia & 32'hFFFF_FFFC;
         e.store    = 32'd0;
         e.imem     = m_imem;
         e.dmem     = m_dmem;
         e.err      = m_err;
         e.len      = len_f;
         exp_q.push_back(e);
      end
      // Edges from request to ready: grant edge + BUSY cycles; a fetch that
      // loses arbitration also waits for the data RESP and one IDLE cycle.
      want_d = len_d + 1;
      want_f = has_d ? (len_d + 1) + 1 + (len_f + 1) : len_f + 1;

      @(negedge clk);
      i_req    = f;
      d_ren    = dr;
      d_wen    = dw;
      imemaddr = ia;
      dmmaddr  = da;
      dmmstore = ds;
      pend_d   = has_d;
      pend_f   = f;
      n        = 0;
      while ((pend_d || pend_f) && n < 100) begin
         @(negedge clk);
         n++;
         if (pend_d && d_ready) begin
            check("d_latency", n, want_d);
            pend_d = 1'b0;
            d_ren  = 1'b0;
            d_wen  = 1'b0;
         end
         if (pend_f && i_ready) begin
            check("i_latency", n, want_f);
            pend_f = 1'b0;
            i_req  = 1'b0;
         end
         // Inputs of an access already granted must not affect it.
         dmmaddr  = $urandom;
         dmmstore = $urandom;
         if (!pend_f || !has_d) imemaddr = $urandom;
      end
      check("txn_done", 32'(pend_d || pend_f), 32'd0);
   endtask

   // Reset while a data read is stuck in BUSY.
   task automatic reset_mid_access();
      exp_t  e;
      plan_t p;
      p.lat  = 1000;
      p.data = '0;
      plan_q.push_back(p);
      e.owner    = 1'b1;
      e.is_write = 1'b0;
      e.addr     = 32'h0000_0ABC;
      e.store    = 32'd0;
      e.imem     = m_imem;
      e.dmem     = m_dmem;
      e.err      = m_err;
      e.len      = 0;
      exp_q.push_back(e);
      @(negedge clk);
      d_ren   = 1'b1;
      dmmaddr = 32'h0000_0ABE;
      @(negedge clk);
      @(negedge clk);
      check("busy_before_reset", 32'(ram_ren), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      d_ren = 1'b0;
      check("rst_ram_ren",   32'(ram_ren),   32'd0);
      check("rst_ram_wen",   32'(ram_wen),   32'd0);
      check("rst_i_ready",   32'(i_ready),   32'd0);
      check("rst_d_ready",   32'(d_ready),   32'd0);
      check("rst_bus_error", 32'(bus_error), 32'd0);
      check("rst_ramaddr",   ramaddr,  32'd0);
      check("rst_imemload",  imemload, 32'd0);
      check("rst_dmmload",   dmmload,  32'd0);
      exp_q.delete();
      plan_q.delete();
      m_imem = 32'd0;
      m_dmem = 32'd0;
      m_err  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", 32'({ram_ren, ram_wen, i_ready, d_ready}), 32'd0);
      end
   endtask

   function automatic int rand_lat();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(TIMEOUT, TIMEOUT + 3));
      return int'($urandom_range(0, TIMEOUT - 1));
   endfunction

   initial begin : stimulus
      bit f;
      bit dr;
      bit dw;
      reset    = 1'b1;
      i_req    = 1'b0;
      d_ren    = 1'b0;
      d_wen    = 1'b0;
      imemaddr = '0;
      dmmaddr  = '0;
      dmmstore = '0;
      m_imem   = '0;
      m_dmem   = '0;
      m_err    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state, then a quiet idle period.
      check("reset_imemload",  imemload, 32'd0);
      check("reset_dmmload",   dmmload,  32'd0);
      check("reset_ramaddr",   ramaddr,  32'd0);
      check("reset_ramstore",  ramstore, 32'd0);
      check("reset_flags", 32'({ram_ren, ram_wen, i_ready, d_ready, bus_error}), 32'd0);
      repeat (10) begin
         @(negedge clk);
         check("idle_strobes", 32'({ram_ren, ram_wen}), 32'd0);
      end

      // Fetch with immediate RAM completion.
      run_txn(1, 0, 0, 32'h0000_0046, '0, '0, 0, '0, 0, 32'h0050_0093);
      // Collision: data served first, fetch after.
      run_txn(1, 1, 0, 32'h0000_0204, 32'h0000_0300, '0,
              1, 32'hDEAD_BEEF, 0, 32'h1234_5678);
      // Store with three wait cycles.
      run_txn(0, 0, 1, '0, 32'h0000_0100, 32'hCAFE_F00D, 3, 32'h5555_5555, 0, '0);
      // Watchdog abort of a fetch, then a normal read.
      run_txn(1, 0, 0, 32'h0000_0080, '0, '0, 0, '0, 100, 32'hFFFF_FFFF);
      check("bus_error_sticky", 32'(bus_error), 32'd1);
      run_txn(0, 1, 0, '0, 32'h0000_0404, '0, 1, 32'hA5A5_0001, 0, '0);
      check("bus_error_still", 32'(bus_error), 32'd1);
      // Reset in the middle of an access.
      reset_mid_access();

      // Randomized traffic.
      for (int t = 0; t < 80; t++) begin
         f  = 1'b0;
         dr = 1'b0;
         dw = 1'b0;
         case ($urandom_range(0, 5))
            0: f  = 1'b1;
            1: dr = 1'b1;
            2: dw = 1'b1;
            3: begin dr = 1'b1; dw = 1'b1; end
            4: begin f  = 1'b1; dr = 1'b1; end
            default: begin f = 1'b1; dw = 1'b1; end
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_txn(f, dr, dw, $urandom, $urandom, $urandom,
                 rand_lat(), $urandom, rand_lat(), $urandom);
      end
      reset_mid_access();
      run_txn(1, 1, 1, 32'h0000_1002, 32'h0000_2003, 32'h0BAD_CAFE,
              2, 32'h1111_1111, 3, 32'h2222_2222);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : global_watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
